// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares a single 16x8 program/data RAM (asynchronous read,
//               write on rising clock) between the CPU datapath and a
//               program-loader requester. CPU strobes pass straight through
//               with zero added latency and always win; the loader uses a
//               req/ack handshake and is served only in CPU-idle cycles.
//
// Ports       : clock, clear          - clock, synchronous active-high reset
//               cpu_addr/wdata/rd/wr  - CPU access (MAR, bus, ram_out, ram_in)
//               cpu_halted            - CPU halted flag
//               cpu_rdata             - read data to bus (= ram_rdata)
//               ld_req/we/addr/wdata  - loader request, held until ld_ack
//               ld_ack, ld_rdata      - loader completion pulse / read data
//               ram_addr/we/wdata     - RAM macro drive
//               ram_rdata             - RAM asynchronous read data
//               owner                 - 00 none, 01 CPU, 10 loader
//               conflict              - sticky, cpu_rd & cpu_wr seen together
//               ld_starved            - sticky loader starvation flag
//
// Build macro : RAM_ARB_LOAD_WHILE_RUN_EN - when defined, the loader may use
//               any CPU-idle cycle even while the CPU runs; otherwise the
//               loader is only served while cpu_halted=1.
//
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 16,
    parameter int WAIT_W       = 8
) (
    input  logic              clock,
    input  logic              clear,
    // CPU side
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_halted,
    output logic [DATA_W-1:0] cpu_rdata,
    // Loader side
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    // RAM macro side
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    // Status
    output logic [1:0]        owner,
    output logic              conflict,
    output logic              ld_starved
);

    typedef enum logic [0:0] {
        L_IDLE = 1'b0,
        L_RESP = 1'b1
    } state_t;

    localparam logic [WAIT_W-1:0] c_WAIT_MAX = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] c_STARVE   = WAIT_W'(STARVE_LIMIT);

    localparam logic [1:0] c_OWN_NONE = 2'b00;
    localparam logic [1:0] c_OWN_CPU  = 2'b01;
    localparam logic [1:0] c_OWN_LD   = 2'b10;

    state_t              r_state;
    logic                r_ld_ack;
    logic [DATA_W-1:0]   r_ld_rdata;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_ld_starved;
    logic                r_conflict;

    logic                w_cpu_act;
    logic                w_loader_ok;
    logic                w_grant;
    logic [WAIT_W-1:0]   w_wait_next;

    assign w_cpu_act = cpu_rd | cpu_wr;

`ifdef RAM_ARB_LOAD_WHILE_RUN_EN
    // Loader steals any CPU-idle cycle; the halted flag is irrelevant here.
    assign w_loader_ok = 1'b1;
`else
    assign w_loader_ok = cpu_halted;
`endif

    // Grant is suppressed during clear so no loader write reaches the RAM
    // in a reset cycle.
    assign w_grant = (r_state == L_IDLE) & ld_req & ~w_cpu_act & w_loader_ok & ~clear;

    // RAM drive mux: CPU first, then loader grant, otherwise park at zero.
    // Only one source can be selected, so owner can never read 11.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        owner     = c_OWN_NONE;
        if (w_cpu_act) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_wr;   // write wins when both strobes are high
            owner     = c_OWN_CPU;
        end else if (w_grant) begin
            ram_addr  = ld_addr;
            ram_wdata = ld_wdata;
            ram_we    = ld_we;
            owner     = c_OWN_LD;
        end
    end

    // Starvation counter: counts blocked idle cycles with a pending request,
    // holds through the response cycle, and restarts on grant or idle req.
    always_comb begin
        w_wait_next = r_wait_cnt;
        if (!ld_req || w_grant) begin
            w_wait_next = '0;
        end else if (r_state == L_IDLE) begin
            if (r_wait_cnt != c_WAIT_MAX) begin
                w_wait_next = r_wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state      <= L_IDLE;
            r_ld_ack     <= 1'b0;
            r_ld_rdata   <= '0;
            r_wait_cnt   <= '0;
            r_ld_starved <= 1'b0;
            r_conflict   <= 1'b0;
        end else begin
            r_wait_cnt   <= w_wait_next;
            r_ld_starved <= r_ld_starved | (w_wait_next >= c_STARVE);
            r_conflict   <= r_conflict | (cpu_rd & cpu_wr);

            case (r_state)
                L_IDLE: begin
                    r_ld_ack <= 1'b0;
                    if (w_grant) begin
                        r_state  <= L_RESP;
                        r_ld_ack <= 1'b1;
                        if (!ld_we) begin
                            r_ld_rdata <= ram_rdata;
                        end
                    end
                end
                L_RESP: begin
                    // Ack completes regardless of cpu_halted changing.
                    r_state  <= L_IDLE;
                    r_ld_ack <= 1'b0;
                end
                default: begin
                    r_state  <= L_IDLE;
                    r_ld_ack <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rdata  = ram_rdata;
    assign ld_ack     = r_ld_ack;
    assign ld_rdata   = r_ld_rdata;
    assign conflict   = r_conflict;
    assign ld_starved = r_ld_starved;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter. Holds a behavioural
//               16x8 RAM (async read, write on rising clock), applies a
//               table of directed vectors with hand-computed expectations,
//               then hand-written sequences for starvation, clear during a
//               response cycle and (with RAM_ARB_LOAD_WHILE_RUN_EN) loader
//               streaming under CPU traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    logic       clk;
    logic       clear;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_rd, cpu_wr, cpu_halted;
    logic [7:0] cpu_rdata;
    logic       ld_req, ld_we;
    logic [3:0] ld_addr;
    logic [7:0] ld_wdata;
    logic       ld_ack;
    logic [7:0] ld_rdata;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [1:0] owner;
    logic       conflict, ld_starved;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [16];

    ram_arbiter #(
        .ADDR_W(4), .DATA_W(8), .STARVE_LIMIT(16), .WAIT_W(8)
    ) dut (
        .clock(clk), .clear(clear),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_halted(cpu_halted),
        .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .owner(owner), .conflict(conflict), .ld_starved(ld_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM macro
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       c_rd, c_wr;
        logic [3:0] c_addr;
        logic [7:0] c_wd;
        logic       l_req, l_we;
        logic [3:0] l_addr;
        logic [7:0] l_wd;
        logic [1:0] e_owner;
        logic       e_we;
        logic [3:0] e_addr;
        logic [7:0] e_wd;
        logic       e_ack;
        logic [7:0] e_lrd;
        logic [7:0] e_crd;
        logic       e_conf;
    } vec_t;

    vec_t vecs [10];

    int   idx, cyc;
    logic prev_ack, got_ack;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[2] = 8'hA1;

        //          rd wr addr  wd     req we laddr lwd    own   we addr  wd     ack lrd    crd    conf
        vecs[0] = '{0, 0, 4'h0, 8'h00, 1, 1, 4'h5, 8'h3C, 2'b10, 1, 4'h5, 8'h3C, 0, 8'h00, 8'h00, 0};
        vecs[1] = '{0, 0, 4'h0, 8'h00, 1, 1, 4'h5, 8'h3C, 2'b00, 0, 4'h0, 8'h00, 1, 8'h00, 8'h00, 0};
        vecs[2] = '{0, 0, 4'h0, 8'h00, 1, 0, 4'h5, 8'h00, 2'b10, 0, 4'h5, 8'h00, 0, 8'h00, 8'h3C, 0};
        vecs[3] = '{0, 0, 4'h0, 8'h00, 1, 0, 4'h5, 8'h00, 2'b00, 0, 4'h0, 8'h00, 1, 8'h3C, 8'h00, 0};
        vecs[4] = '{1, 0, 4'h2, 8'h00, 1, 0, 4'h2, 8'h00, 2'b01, 0, 4'h2, 8'h00, 0, 8'h3C, 8'hA1, 0};
        vecs[5] = '{0, 0, 4'h0, 8'h00, 1, 0, 4'h2, 8'h00, 2'b10, 0, 4'h2, 8'h00, 0, 8'h3C, 8'hA1, 0};
        vecs[6] = '{0, 0, 4'h0, 8'h00, 1, 0, 4'h2, 8'h00, 2'b00, 0, 4'h0, 8'h00, 1, 8'hA1, 8'h00, 0};
        vecs[7] = '{1, 1, 4'h7, 8'h55, 0, 0, 4'h0, 8'h00, 2'b01, 1, 4'h7, 8'h55, 0, 8'hA1, 8'h00, 0};
        vecs[8] = '{1, 0, 4'h7, 8'h00, 0, 0, 4'h0, 8'h00, 2'b01, 0, 4'h7, 8'h00, 0, 8'hA1, 8'h55, 1};
        vecs[9] = '{0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 2'b00, 0, 4'h0, 8'h00, 0, 8'hA1, 8'h00, 1};

        // Reset
        clear = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_rd = 0; cpu_wr = 0; cpu_halted = 1;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
        tick();
        tick();
        #3;
        chk("rst_ack",      ld_ack,     0);
        chk("rst_ld_rdata", ld_rdata,   0);
        chk("rst_starved",  ld_starved, 0);
        chk("rst_conflict", conflict,   0);
        chk("rst_owner",    owner,      0);
        clear = 1'b0;

        // Table-driven vectors, CPU halted
        for (int i = 0; i < 10; i++) begin
            cpu_rd = vecs[i].c_rd;     cpu_wr = vecs[i].c_wr;
            cpu_addr = vecs[i].c_addr; cpu_wdata = vecs[i].c_wd;
            ld_req = vecs[i].l_req;    ld_we = vecs[i].l_we;
            ld_addr = vecs[i].l_addr;  ld_wdata = vecs[i].l_wd;
            #3;
            chk($sformatf("v%0d_owner", i),     owner,      vecs[i].e_owner);
            chk($sformatf("v%0d_ram_we", i),    ram_we,     vecs[i].e_we);
            chk($sformatf("v%0d_ram_addr", i),  ram_addr,   vecs[i].e_addr);
            chk($sformatf("v%0d_ram_wdata", i), ram_wdata,  vecs[i].e_wd);
            chk($sformatf("v%0d_ld_ack", i),    ld_ack,     vecs[i].e_ack);
            chk($sformatf("v%0d_ld_rdata", i),  ld_rdata,   vecs[i].e_lrd);
            chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata,  vecs[i].e_crd);
            chk($sformatf("v%0d_conflict", i),  conflict,   vecs[i].e_conf);
            chk($sformatf("v%0d_starved", i),   ld_starved, 0);
            tick();
        end
        chk("mem5_written", mem[5], 8'h3C);
        chk("mem7_written", mem[7], 8'h55);

`ifndef RAM_ARB_LOAD_WHILE_RUN_EN
        // Starvation: CPU running, loader blocked for 20 cycles
        cpu_halted = 0;
        cpu_rd = 0; cpu_wr = 0;
        ld_req = 1; ld_we = 1; ld_addr = 4'h3; ld_wdata = 8'h77;
        for (int i = 0; i < 20; i++) begin
            #3;
            chk($sformatf("starve_c%0d_flag", i),  ld_starved, (i >= 16) ? 1 : 0);
            chk($sformatf("starve_c%0d_owner", i), owner,      0);
            tick();
        end
        ld_req = 0;
        #3;
        chk("starve_sticky_a", ld_starved, 1);
        tick();
        #3;
        chk("starve_sticky_b", ld_starved, 1);
        chk("mem3_untouched",  mem[3],     0);
        tick();
`else
        // Loader streams 4 writes while the CPU strobes every 2-3 cycles
        cpu_halted = 0;
        idx = 0; cyc = 0; prev_ack = 0;
        while (idx < 4 && cyc < 60) begin
            cpu_rd   = ((cyc % 5) == 0) || ((cyc % 5) == 2);
            cpu_wr   = 0;
            cpu_addr = 4'h2;
            ld_req   = 1; ld_we = 1;
            ld_addr  = 4'(8 + idx);
            ld_wdata = 8'(8'hC0 + idx);
            #3;
            chk("stream_owner_valid", (owner != 2'b11) ? 1 : 0, 1);
            if (cpu_rd) chk("stream_cpu_owner", owner, 1);
            chk("stream_ack_width", (prev_ack & ld_ack) ? 1 : 0, 0);
            got_ack  = ld_ack;
            prev_ack = ld_ack;
            tick();
            cyc++;
            if (got_ack) idx++;
        end
        cpu_rd = 0; ld_req = 0;
        chk("stream_done_in_budget", idx, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stream_mem%0d", 8 + k), mem[8 + k], 8'hC0 + k);
        end
        tick();
`endif

        // Clear arriving in a response cycle
        cpu_halted = 1;
        cpu_rd = 0; cpu_wr = 0;
        ld_req = 1; ld_we = 0; ld_addr = 4'h7; ld_wdata = 8'h00;
        #3;
        chk("clr_issue_owner", owner, 2);
        tick();
        #3;
        chk("clr_resp_ack",    ld_ack,   1);
        chk("clr_resp_rdata",  ld_rdata, 8'h55);
        clear = 1;
        tick();
        // clear still high: a loader write must not be issued
        ld_we = 1; ld_addr = 4'h3; ld_wdata = 8'h99;
        #3;
        chk("clr_ack_dropped", ld_ack,   0);
        chk("clr_rdata_zero",  ld_rdata, 0);
        chk("clr_owner_none",  owner,    0);
        chk("clr_no_write",    ram_we,   0);
        tick();
        clear = 0;
        ld_we = 0; ld_addr = 4'h3;
        #3;
        chk("post_clr_idle_grant", owner,      2);
        chk("post_clr_mem3",       cpu_rdata,  0);
        chk("post_clr_conflict",   conflict,   0);
        chk("post_clr_starved",    ld_starved, 0);
        chk("post_clr_ack",        ld_ack,     0);
        tick();
        #3;
        chk("post_clr_read_ack",   ld_ack,     1);
        chk("post_clr_read_data",  ld_rdata,   0);
        ld_req = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
